sm3_expnd_core: RTL

//   SM3 message expansion stage; sits directly upstream of the single-round compression logic.

---
 rtl/sm3_expnd_core_if.sv | 27 ++
 rtl/sm3_expnd_core.sv | 84 ++++++++
 2 files changed

// File: rtl/sm3_expnd_core_if.sv
// Block-in / round-out handshake bundle for the SM3 message expansion core.
interface sm3_expnd_core_if;
   logic         blk_vld_i;
   logic         blk_rdy_o;
   logic [511:0] blk_i;
   logic         wj_vld_o;
   logic         wj_rdy_i;
   logic [31:0]  wj_o;
   logic [31:0]  wjj_o;
   logic [31:0]  tj_o;
   logic [5:0]   round_o;
   logic         round_sm_16_o;
   logic         last_round_o;
   logic         busy_o;

   modport slave (
      input  blk_vld_i, blk_i, wj_rdy_i,
      output blk_rdy_o, wj_vld_o, wj_o, wjj_o, tj_o, round_o,
             round_sm_16_o, last_round_o, busy_o
   );

   modport master (
      output blk_vld_i, blk_i, wj_rdy_i,
      input  blk_rdy_o, wj_vld_o, wj_o, wjj_o, tj_o, round_o,
             round_sm_16_o, last_round_o, busy_o
   );
endinterface

// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: 16-word sliding window producing W_j, W'_j and T_j,
// one round per handshake, for j = 0..ROUND_NUM-1.
module sm3_expnd_core #(
   parameter int unsigned ROUND_NUM = 64,
   parameter logic [31:0] T_LO      = 32'h79cc4519,
   parameter logic [31:0] T_HI      = 32'h7a879d8a
) (
   input logic               clk,
   input logic               rst_n,
   sm3_expnd_core_if.slave   bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [15:0][31:0]   w;
   logic [5:0]          round;
   logic                blk_acc;
   logic                rnd_acc;
   logic                last;
   logic [31:0]         w_new;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] d;
      d = {x, x} << n;
      return d[63:32];
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
   endfunction

   assign last  = (round == 6'(ROUND_NUM - 1));
   assign w_new = p1(w[0] ^ w[7] ^ rotl(w[13], 5'd15)) ^ rotl(w[3], 5'd7) ^ w[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      blk_acc   = 1'b0;
      rnd_acc   = 1'b0;
      case (state)
         IDLE: begin
            blk_acc = bus.blk_vld_i;
            if (blk_acc) state_nxt = RUN;
         end
         RUN: begin
            rnd_acc = bus.wj_rdy_i;
            if (rnd_acc && last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Window slot k always holds W_(round+k); a round accept shifts in W_(round+16).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w     <= '0;
         round <= '0;
      end else if (blk_acc) begin
         for (int unsigned i = 0; i < 16; i++)
            w[i] <= bus.blk_i[511 - 32*i -: 32];
         round <= '0;
      end else if (rnd_acc) begin
         w     <= {w_new, w[15:1]};
         round <= last ? '0 : round + 6'd1;
      end
   end

   assign bus.blk_rdy_o     = (state == IDLE);
   assign bus.wj_vld_o      = (state == RUN);
   assign bus.busy_o        = (state == RUN);
   assign bus.wj_o          = w[0];
   assign bus.wjj_o         = w[0] ^ w[4];
   assign bus.tj_o          = rotl((round < 6'd16) ? T_LO : T_HI, round[4:0]);
   assign bus.round_o       = round;
   assign bus.round_sm_16_o = (round < 6'd16);
   assign bus.last_round_o  = (state == RUN) && last;

endmodule
